// File: rtl/lcd_frame_copier.sv
// Bus master that copies a PAGES x COLS monochrome framebuffer from RAM into the
// LCD controller through its command (page/column) and data ports.
module lcd_frame_copier #(
   parameter logic [23:0] FB_BASE       = 24'h001000,
   parameter logic [23:0] LCD_CMD_ADDR  = 24'h0020FE,
   parameter logic [23:0] LCD_DATA_ADDR = 24'h0020FF,
   parameter int          COLS          = 96,
   parameter int          PAGES         = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_ce,
   input  logic        start,
   input  logic        bus_ack,
   input  logic [7:0]  data_in,
   output logic        bus_request,
   output logic        busy,
   output logic        done,
   output logic [23:0] address_out,
   output logic [7:0]  data_out,
   output logic        bus_write,
   output logic        bus_read,
   output logic [3:0]  state_dbg
);

   typedef enum logic [3:0] {
      IDLE, REQ, CMD, CMD_GAP, RD, RD_WAIT, WR, WR_GAP, DONE
   } state_t;

   state_t     state;
   logic [3:0] page;
   logic [7:0] col;
   logic [1:0] cmd_idx;
   logic [7:0] byte_reg;

   assign state_dbg = state;

   function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [3:0] p);
      case (idx)
         2'd0:    cmd_byte = 8'hB0 | {4'h0, p};
         2'd1:    cmd_byte = 8'h00;
         default: cmd_byte = 8'h10;
      endcase
   endfunction

   function automatic logic [23:0] rd_addr(input logic [3:0] p, input logic [7:0] c);
      rd_addr = FB_BASE + 24'(p) * 24'(COLS) + 24'(c);
   endfunction

   // Bus handshake: a strobe only takes effect in a clk_ce cycle where bus_ack is
   // high. A strobe state advances only once its strobe was presented with the
   // grant; when bus_ack drops the strobe is withdrawn and re-presented on return.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         page        <= 4'd0;
         col         <= 8'd0;
         cmd_idx     <= 2'd0;
         byte_reg    <= 8'h00;
         bus_request <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         address_out <= 24'h0;
         data_out    <= 8'h00;
         bus_write   <= 1'b0;
         bus_read    <= 1'b0;
      end else if (clk_ce) begin
         done      <= 1'b0;
         bus_write <= 1'b0;
         bus_read  <= 1'b0;
         data_out  <= 8'h00;
         case (state)
            IDLE: if (start) begin
               state       <= REQ;
               busy        <= 1'b1;
               bus_request <= 1'b1;
               page        <= 4'd0;
               col         <= 8'd0;
               cmd_idx     <= 2'd0;
            end
            REQ: if (bus_ack) begin
               state       <= CMD;
               cmd_idx     <= 2'd0;
               bus_write   <= 1'b1;
               address_out <= LCD_CMD_ADDR;
               data_out    <= cmd_byte(2'd0, page);
            end
            CMD: if (bus_ack) begin
               if (bus_write) state <= CMD_GAP;
               else begin
                  bus_write <= 1'b1;
                  data_out  <= cmd_byte(cmd_idx, page);
               end
            end
            CMD_GAP: if (bus_ack) begin
               if (cmd_idx != 2'd2) begin
                  cmd_idx     <= cmd_idx + 2'd1;
                  state       <= CMD;
                  bus_write   <= 1'b1;
                  address_out <= LCD_CMD_ADDR;
                  data_out    <= cmd_byte(cmd_idx + 2'd1, page);
               end else begin
                  state       <= RD;
                  bus_read    <= 1'b1;
                  address_out <= rd_addr(page, col);
               end
            end
            RD: if (bus_ack) begin
               if (bus_read) state <= RD_WAIT;
               else          bus_read <= 1'b1;
            end
            RD_WAIT: if (bus_ack) begin
               byte_reg    <= data_in;
               state       <= WR;
               bus_write   <= 1'b1;
               address_out <= LCD_DATA_ADDR;
               data_out    <= data_in;
            end
            WR: if (bus_ack) begin
               if (bus_write) state <= WR_GAP;
               else begin
                  bus_write <= 1'b1;
                  data_out  <= byte_reg;
               end
            end
            WR_GAP: if (bus_ack) begin
               if (col < 8'(COLS - 1)) begin
                  col         <= col + 8'd1;
                  state       <= RD;
                  bus_read    <= 1'b1;
                  address_out <= rd_addr(page, col + 8'd1);
               end else begin
                  col <= 8'd0;
                  if (page < 4'(PAGES - 1)) begin
                     page        <= page + 4'd1;
                     cmd_idx     <= 2'd0;
                     state       <= CMD;
                     bus_write   <= 1'b1;
                     address_out <= LCD_CMD_ADDR;
                     data_out    <= cmd_byte(2'd0, page + 4'd1);
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            // DONE never touches the bus, so it completes without waiting for the grant.
            DONE: begin
               state       <= IDLE;
               busy        <= 1'b0;
               bus_request <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_frame_copier.sv
// Bench for lcd_frame_copier: expected bus transactions are queued per frame and
// compared as they appear; an LCD model rebuilds the panel from the bus writes.
module tb_lcd_frame_copier;
   localparam int          COLS   = 96;
   localparam int          PAGES  = 8;
   localparam int          NBYTES = COLS * PAGES;
   localparam logic [23:0] FB_BASE = 24'h001000;
   localparam logic [23:0] CMD_A   = 24'h0020FE;
   localparam logic [23:0] DATA_A  = 24'h0020FF;
   localparam int          W = 34;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_ce = 1'b1;
   logic        start = 1'b0;
   logic        bus_ack = 1'b1;
   logic [7:0]  data_in = 8'h00;
   logic        bus_request, busy, done, bus_write, bus_read;
   logic [23:0] address_out;
   logic [7:0]  data_out;
   logic [3:0]  state_dbg;

   lcd_frame_copier dut (
      .clk(clk), .reset(reset), .clk_ce(clk_ce), .start(start), .bus_ack(bus_ack),
      .data_in(data_in), .bus_request(bus_request), .busy(busy), .done(done),
      .address_out(address_out), .data_out(data_out), .bus_write(bus_write),
      .bus_read(bus_read), .state_dbg(state_dbg)
   );

   // clock / clock-enable
   always #5 clk = ~clk;
   int ce_mode = 2;  // 0 random, 1 forced low, 2 forced high
   always @(posedge clk) begin
      #1;
      if (ce_mode == 0) clk_ce = ($urandom_range(0, 3) != 0);
      else              clk_ce = (ce_mode == 2);
   end

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];
   logic [7:0]   ram [0:NBYTES-1];
   logic [7:0]   lcd [0:NBYTES-1];
   int  lcd_page, lcd_col;
   int  done_count, data_wr_count, data_wr_strobes, cyc, t0;
   bit  t0_valid, check_timing;
   bit  prev_ack, prev_strobe, prev_done;
   logic [23:0] last_rd_addr;
   bit  drop_armed, restart_armed, reset_armed;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ce();
      do @(posedge clk); while (clk_ce !== 1'b1);
      #1;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (reset) begin
         prev_ack = 1'b0; prev_strobe = 1'b0; prev_done = 1'b0;
      end else if (clk_ce) begin
         logic [W-1:0] got;
         cyc++;
         if (prev_done) begin
            check("busy_after_done", busy, 0);
            check("request_after_done", bus_request, 0);
         end
         if (bus_write || bus_read) begin
            check("strobe_exclusive", bus_write & bus_read, 0);
            check("strobe_not_back_to_back", prev_strobe, 0);
            check("strobe_needs_prior_grant", prev_ack, 1);
         end else begin
            check("data_out_idle_zero", data_out, 0);
         end
         if (bus_write && address_out == DATA_A) data_wr_strobes++;
         if ((bus_write || bus_read) && bus_ack) begin
            got = {bus_write ? 2'b01 : 2'b10, address_out, bus_read ? 8'h00 : data_out};
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_txn: got %0h, expected none", got);
            end else begin
               check("bus_txn", got, exp_q.pop_front());
            end
            if (bus_read) begin
               last_rd_addr = address_out;
               if (address_out >= FB_BASE && address_out < FB_BASE + 24'(NBYTES))
                  data_in = ram[int'(address_out - FB_BASE)];
               else
                  data_in = 8'h00;
            end else if (address_out == CMD_A) begin
               if (!t0_valid) begin t0 = cyc; t0_valid = 1'b1; end
               if (data_out[7:4] == 4'hB)      lcd_page = int'(data_out[3:0]);
               else if (data_out[7:4] == 4'h0) lcd_col = (lcd_col & 'hF0) | int'(data_out[3:0]);
               else if (data_out[7:4] == 4'h1) lcd_col = (lcd_col & 'h0F) | (int'(data_out[3:0]) << 4);
            end else if (address_out == DATA_A) begin
               if (lcd_page < PAGES && lcd_col < COLS) lcd[lcd_page * COLS + lcd_col] = data_out;
               lcd_col++;
               data_wr_count++;
            end
         end
         if (done) begin
            done_count++;
            if (check_timing) check("done_timing", cyc - t0, 3120);
         end
         prev_ack = bus_ack; prev_strobe = bus_write | bus_read; prev_done = done;
      end
   end

   // driver tasks
   task automatic fill_ram(input bit pattern);
      for (int i = 0; i < NBYTES; i++) begin
         logic [23:0] a;
         a = FB_BASE + 24'(i);
         ram[i] = pattern ? (a[7:0] ^ 8'h5A) : 8'($urandom_range(0, 255));
      end
   endtask

   task automatic issue_start();
      done_count = 0; data_wr_count = 0; data_wr_strobes = 0; t0_valid = 1'b0;
      lcd_page = 0; lcd_col = 0;
      for (int i = 0; i < NBYTES; i++) lcd[i] = 8'hxx;
      for (int p = 0; p < PAGES; p++) begin
         logic [7:0] b0;
         b0 = 8'hB0 + 8'(p);
         exp_q.push_back({2'b01, CMD_A, b0});
         exp_q.push_back({2'b01, CMD_A, 8'h00});
         exp_q.push_back({2'b01, CMD_A, 8'h10});
         for (int c = 0; c < COLS; c++) begin
            exp_q.push_back({2'b10, FB_BASE + 24'(p * COLS + c), 8'h00});
            exp_q.push_back({2'b01, DATA_A, ram[p * COLS + c]});
         end
      end
      start = 1'b1;
      wait_ce();
      start = 1'b0;
   endtask

   task automatic run_until_done(input int max_clks, output bit aborted);
      int n = 0;
      aborted = 1'b0;
      while (done_count == 0 && n < max_clks) begin
         @(posedge clk); #1; n++;
         if (drop_armed && bus_write && address_out == DATA_A && data_wr_count == 3 * COLS + 40) begin
            drop_armed = 1'b0;
            bus_ack = 1'b0;
            for (int k = 0; k < 5; k++) begin
               wait_ce();
               check("stall_strobes_low", {bus_write, bus_read}, 0);
            end
            bus_ack = 1'b1;
         end
         if (restart_armed && data_wr_count >= 2 * COLS + 5) begin
            restart_armed = 1'b0;
            start = 1'b1;
            wait_ce();
            start = 1'b0;
         end
         if (reset_armed && data_wr_count >= 5 * COLS) begin
            reset_armed = 1'b0;
            ce_mode = 1;
            @(posedge clk); #2;
            reset = 1'b1;
            @(posedge clk); #1;
            check("reset_mid_flags", {bus_request, busy, done, bus_write, bus_read}, 0);
            check("reset_mid_addr", address_out, 0);
            check("reset_mid_data", data_out, 0);
            check("reset_mid_state", state_dbg, 0);
            @(posedge clk); #1;
            exp_q.delete();
            reset = 1'b0;
            ce_mode = 0;
            aborted = 1'b1;
            return;
         end
      end
      if (done_count == 0) begin
         checks++; errors++;
         $display("FAIL frame_timeout: got no done within %0d clocks, expected done", max_clks);
      end
   endtask

   task automatic post_frame(input int exp_strobes);
      int bad = 0;
      repeat (2) wait_ce();
      check("done_pulses", done_count, 1);
      check("data_writes", data_wr_count, NBYTES);
      check("data_write_strobes", data_wr_strobes, exp_strobes);
      check("queue_drained", exp_q.size(), 0);
      check("last_read_addr", last_rd_addr, 24'h0012FF);
      check("idle_after_frame", {busy, bus_request}, 0);
      for (int i = 0; i < NBYTES; i++) if (lcd[i] !== ram[i]) bad++;
      check("lcd_matches_ram", bad, 0);
      exp_q.delete();
   endtask

   initial begin
      bit ab;
      repeat (3) @(posedge clk);
      #1;
      check("reset_flags", {bus_request, busy, done, bus_write, bus_read}, 0);
      check("reset_addr", address_out, 0);
      check("reset_data", data_out, 0);
      reset = 1'b0;
      ce_mode = 0;

      // full frame, grant always present, RAM = addr ^ 0x5A
      fill_ram(1'b1);
      check_timing = 1'b1;
      issue_start();
      run_until_done(12000, ab);
      post_frame(NBYTES);

      // grant withheld for 20 cycles after start
      fill_ram(1'b0);
      bus_ack = 1'b0;
      issue_start();
      for (int k = 0; k < 20; k++) begin
         wait_ce();
         check("no_grant_request", {bus_request, bus_write, bus_read}, 3'b100);
      end
      bus_ack = 1'b1;
      wait_ce();
      check("first_cmd_on_grant", {bus_write, address_out, data_out}, {1'b1, CMD_A, 8'hB0});
      run_until_done(12000, ab);
      post_frame(NBYTES);

      // grant drop during a data write plus an ignored second start
      fill_ram(1'b0);
      check_timing = 1'b0;
      drop_armed = 1'b1;
      restart_armed = 1'b1;
      issue_start();
      run_until_done(12000, ab);
      post_frame(NBYTES + 1);
      check("drop_fired", drop_armed, 0);

      // reset mid-copy with clk_ce low, then a clean restart
      fill_ram(1'b0);
      reset_armed = 1'b1;
      issue_start();
      run_until_done(12000, ab);
      check("reset_aborted", ab, 1);
      repeat (40) @(posedge clk);
      #1;
      check("no_done_after_reset", done_count, 0);
      check("idle_after_reset", {bus_request, busy}, 0);
      check_timing = 1'b1;
      issue_start();
      run_until_done(12000, ab);
      post_frame(NBYTES);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lcd_frame_copier.md
Name: lcd_frame_copier

Overview:
- Bus master that copies a 96x64 monochrome framebuffer (8 pages x 96 bytes) from system RAM into the LCD controller.
- Issues page/column commands to 0x20FE and data writes to 0x20FF over the shared 24-bit bus.
- Sits beside the CPU as a second bus initiator, requesting the bus via a request/acknowledge pair. Driven by a start pulse from the render/timer logic.

Parameters:
- FB_BASE, 24'h001000, RAM address of framebuffer byte (page 0, column 0); byte (p,c) lives at FB_BASE + p*COLS + c
- LCD_CMD_ADDR, 24'h0020FE, LCD command port
- LCD_DATA_ADDR, 24'h0020FF, LCD data port
- COLS, 96, bytes per page (1..132)
- PAGES, 8, pages per frame (1..9)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_ce  in  1  clock enable; all state advances only when high (except reset)
- start  in  1  copy request, sampled on clk_ce cycles
- bus_ack  in  1  bus grant from arbiter
- data_in  in  8  RAM read data
- bus_request  out  1  bus ownership request
- busy  out  1  high from accepted start until done
- done  out  1  one-clk_ce-cycle pulse at copy completion
- address_out  out  24  bus address
- data_out  out  8  bus write data
- bus_write  out  1  write strobe
- bus_read  out  1  read strobe

Behaviour:
- Reset:
  - Takes effect on any clk edge with reset=1, independent of clk_ce.
  - State returns to IDLE. All outputs are 0, including address_out and data_out. Page and column counters clear.
  - Reset mid-copy abandons the transfer with no done pulse, and bus_request drops on the next edge.
- States: IDLE, REQ, CMD, CMD_GAP, RD, RD_WAIT, WR, WR_GAP, DONE. Each state lasts one clk_ce cycle unless stalled.
- IDLE:
  - start=1 -> REQ; busy=1 and bus_request=1 from the next cycle.
  - start while busy is ignored (not queued).
- REQ: wait for bus_ack=1, then go to CMD with cmd_idx=0.
- CMD:
  - bus_write=1, address_out=LCD_CMD_ADDR.
  - data_out by cmd_idx: 0 -> 8'hB0|page, 1 -> 8'h00 (column low=0), 2 -> 8'h10 (column high=0).
  - Then CMD_GAP.
- CMD_GAP:
  - bus_write=0. The LCD controller is edge-triggered, so each write strobe is followed by at least one low clk_ce cycle.
  - If cmd_idx<2: increment cmd_idx and go to CMD. Else go to RD.
- RD: bus_read=1, address_out=FB_BASE+page*COLS+col (24-bit, wraps modulo 2^24) -> RD_WAIT.
- RD_WAIT: bus_read=0; latch data_in into an 8-bit byte register (read latency 1 clk_ce) -> WR.
- WR: bus_write=1, address_out=LCD_DATA_ADDR, data_out=latched byte -> WR_GAP.
- WR_GAP:
  - bus_write=0.
  - col<COLS-1: col+1, go to RD.
  - Else col=0. If page<PAGES-1: page+1, cmd_idx=0, go to CMD. Else go to DONE.
- DONE: done=1 for one clk_ce cycle; bus_request=0 and busy=0 from the following cycle -> IDLE.
- Stall on bus_ack=0 in any state other than IDLE or REQ:
  - Hold state and counters; force bus_write=0 and bus_read=0.
  - Resume the same state when bus_ack returns. A stalled RD re-issues its read, and a stalled WR re-issues its write after the grant.
- Timing:
  - Per page: 6 command cycles + COLS*4 data cycles.
  - Default frame: 8*(6+384) = 3120 clk_ce cycles from the first CMD to DONE.
- Strobe rules:
  - bus_write and bus_read are never high together.
  - Neither strobe is high for two consecutive clk_ce cycles.
- Outputs are registered. When no strobe is active, address_out holds its last value and data_out=0.

Test Plan:
- Reset then start pulse with bus_ack tied 1:
  - Writes to 0x20FE are B0,00,10.
  - Then 96 reads from 0x001000..0x00105F, each followed by a 0x20FF write of the RAM byte.
  - Then B1,00,10 and so on. done pulses once after exactly 3120 clk_ce cycles; busy falls after it.
- Full frame end to end: RAM model loaded with byte = (addr ^ 0x5A), bench LCD model checked after done.
  - Every LCD (page,col) cell equals the matching RAM byte.
  - Last data address is 0x0012FF.
- bus_ack held 0 for 20 cycles after start: bus_request=1, no strobes; the copy begins on the first ack cycle.
- bus_ack dropped for 5 cycles during a WR at page 3, col 40:
  - Strobes are low throughout the stall.
  - The write to 0x20FF is re-issued exactly once with the same byte, and the frame data is still correct.
- start pulsed again at page 2: ignored; exactly one done pulse and 768 data writes in total.
- reset asserted at page 5 with clk_ce=0: outputs are 0 on the next clk edge, no done pulse; a new start restarts from page 0 with command B0.
